picorv32_mem_arbiter: RTL and testbench
=======================================

# picorv32_mem_arbiter

Two-master round-robin arbiter sharing one single-port synchronous SRAM between the picorv32 native memory interface (master 0, CPU) and a loader/debug port (master 1) using the same valid/ready protocol. Sits between `picorv32_top`'s core and its memory array. It replaces direct hierarchical preloading of `top.mem.memory` with a bus-level path usable while the core runs. It also flags accesses outside the populated memory range.

## Interface
- `MEM_WORDS`, 65536: number of 32-bit words in the SRAM; byte addresses at or above `4*MEM_WORDS` are out of range.
- `AW`, 16: SRAM word-address width; must satisfy 2^AW >= MEM_WORDS.

- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `m0_valid` / `m1_valid` in 1: request; held until matching ready.
- `m0_addr` / `m1_addr` in 32: byte address; bits [1:0] ignored.
- `m0_wdata` / `m1_wdata` in 32: write data.
- `m0_wstrb` / `m1_wstrb` in 4: byte enables; 0 = read.
- `m0_ready` / `m1_ready` out 1: one-cycle completion pulse.
- `m0_rdata` / `m1_rdata` out 32: read data, valid only with own ready.
- `sram_en` out 1: SRAM access strobe.
- `sram_we` out 4: SRAM byte write enables.
- `sram_addr` out AW: SRAM word address.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, one cycle after `sram_en`.
- `err` out 1: one-cycle pulse with the ready of an out-of-range access.
- `err_master` out 1: master index of that access, valid with `err`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any valid, select a master and register `gnt`, word address, wdata, wstrb, and `oor` (address[31:2] >= MEM_WORDS). Go to ACCESS. Otherwise stay in IDLE.
- Selection: if only one master is valid, grant it. If both are valid, grant the one not in `last_gnt`. Update `last_gnt <= gnt` on every grant.
- ACCESS: `sram_en = !oor`, `sram_we = oor ? 0 : wstrb`, addr/wdata from registers. Go to RESP.
- RESP: assert `m<gnt>_ready` only.
- RESP rdata: `sram_rdata` for an in-range read; 32'h0 for any write or out-of-range access. The non-granted master's rdata is 32'h0.
- RESP error: `err = oor`, `err_master = gnt`. Go to IDLE.
- Grant is held for the whole transaction. A valid dropping mid-transaction does not abort it; the ready pulse is still issued.
- A master must deassert valid, or present a new request, in the cycle after ready. IDLE re-evaluates both valids, so a held-high valid counts as a new request.
- `sram_we` is never nonzero while `sram_en` is 0.

## Timing
- Request first seen in IDLE at edge N: `sram_en` high during cycle N+1, ready pulse during cycle N+2, IDLE again at N+3.
- Valid-to-ready latency is 2 cycles. Maximum throughput is one transfer per 3 cycles.
- Fairness: with both masters continuously requesting, grants alternate; a master waits at most one other transaction (3 cycles).
- Reset values, all outputs registered or decoded from registers:
  - state=IDLE, `last_gnt`=1 (so master 0 wins the first tie).
  - `m0_ready`=`m1_ready`=0, rdata=0, `sram_en`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0, `err`=0, `err_master`=0.
- Reset asserted in ACCESS or RESP: the next edge returns to IDLE, suppresses any pending ready/err, and drops `sram_en`. A write already strobed in ACCESS is not undone.
- Simultaneous new requests arriving in RESP are ignored until IDLE.
- Address wrap: only the word-index bits [AW+1:2] drive `sram_addr`. The out-of-range check uses the full 30-bit word index, so aliasing is impossible.

## Test plan
- Reset then single read: m0 reads 0x0000_0010 with SRAM word 4 = 0xDEADBEEF -> `sram_en`=1, `sram_addr`=4 at N+1; `m0_ready`=1 and `m0_rdata`=0xDEADBEEF at N+2; `m1_ready` stays 0.
- Byte write: m1 writes 0x0000_0008, wdata 0x11223344, wstrb 4'b0010 -> `sram_we`=4'b0010, `sram_addr`=2 at N+1; `m1_ready` pulse at N+2 with `m1_rdata`=0.
- Contention: m0 and m1 both valid from reset, held high -> grants m0, m1, m0, m1; ready pulses 3 cycles apart, alternating.
- Out-of-range: MEM_WORDS=1024, m1 reads 0x0000_1000 -> `sram_en` stays 0; `m1_ready`=1, `m1_rdata`=0, `err`=1, `err_master`=1 at N+2.
- Reset mid-op: assert `rst` during ACCESS of an m0 read -> no `m0_ready` pulse ever; all outputs at reset values after the edge; the next request is serviced with normal 2-cycle latency.
- Back-to-back same master: m1 idle, m0 issues 4 sequential reads -> 4 ready pulses at cycles N+2, N+5, N+8, N+11 with correct data.

Source files
------------

// File: rtl/picorv32_mem_arbiter.sv
// picorv32_mem_arbiter: round-robin arbiter sharing one synchronous SRAM between the CPU and a loader port
module picorv32_mem_arbiter #(
  parameter int unsigned MEM_WORDS = 65536,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_valid,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  input  logic          m1_valid,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          err,
  output logic          err_master
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic gnt, last_gnt, oor, rd_ok, sel, oor_s;
  logic [29:0] widx;
  logic [31:0] wdata_s;
  logic [3:0] wstrb_s;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{m0_addr[1:0], m1_addr[1:0]};
  always_comb begin
    sel = (m0_valid && m1_valid) ? !last_gnt : m1_valid;
    widx = sel ? m1_addr[31:2] : m0_addr[31:2];
    wdata_s = sel ? m1_wdata : m0_wdata;
    wstrb_s = sel ? m1_wstrb : m0_wstrb;
    oor_s = 32'(widx) >= MEM_WORDS;
  end
  // read data is only forwarded for an in-range read, and only to the master being answered
  assign m0_rdata = (m0_ready && rd_ok) ? sram_rdata : 32'h0;
  assign m1_rdata = (m1_ready && rd_ok) ? sram_rdata : 32'h0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      last_gnt <= 1'b1;
      oor <= 1'b0;
      rd_ok <= 1'b0;
      sram_en <= 1'b0;
      sram_we <= 4'h0;
      sram_addr <= '0;
      sram_wdata <= 32'h0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      err <= 1'b0;
      err_master <= 1'b0;
    end else begin
      case (state)
        IDLE: if (m0_valid || m1_valid) begin
          state <= ACCESS;
          gnt <= sel;
          last_gnt <= sel;
          oor <= oor_s;
          rd_ok <= !oor_s && wstrb_s == 4'h0;
          sram_en <= !oor_s;
          sram_we <= oor_s ? 4'h0 : wstrb_s;
          sram_addr <= widx[AW-1:0];
          sram_wdata <= wdata_s;
        end
        ACCESS: begin
          state <= RESP;
          sram_en <= 1'b0;
          sram_we <= 4'h0;
          m0_ready <= !gnt;
          m1_ready <= gnt;
          err <= oor;
          err_master <= gnt;
        end
        default: begin
          state <= IDLE;
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          err <= 1'b0;
          err_master <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb_picorv32_mem_arbiter: directed vector bench with a 1024-word SRAM model behind the arbiter
module tb_picorv32_mem_arbiter;
  logic clk = 0, rst = 1;
  logic m0_valid = 0, m1_valid = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic [3:0] m0_wstrb = 0, m1_wstrb = 0;
  logic m0_ready, m1_ready, sram_en, err, err_master;
  logic [31:0] m0_rdata, m1_rdata, sram_wdata, sram_rdata;
  logic [3:0] sram_we;
  logic [9:0] sram_addr;
  logic [31:0] mem [1024];
  bit load = 1;
  int n_checks = 0, n_fail = 0;

  picorv32_mem_arbiter #(.MEM_WORDS(1024), .AW(10)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .err(err), .err_master(err_master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && load) begin
      mem[2] <= 32'hAABBCCDD;
      mem[4] <= 32'hDEADBEEF;
      mem[1023] <= 32'hCAFEF00D;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr];
    end
  end

  typedef struct {
    bit m;
    logic [31:0] addr, wdata;
    logic [3:0] wstrb;
    bit en;
    logic [3:0] we;
    logic [9:0] saddr;
    logic [31:0] rdata;
    bit err;
  } vec_t;
  vec_t v [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " m0_ready"}, 32'(m0_ready), 0);
    chk({tag, " m1_ready"}, 32'(m1_ready), 0);
    chk({tag, " m0_rdata"}, m0_rdata, 0);
    chk({tag, " m1_rdata"}, m1_rdata, 0);
    chk({tag, " sram_en"}, 32'(sram_en), 0);
    chk({tag, " sram_we"}, 32'(sram_we), 0);
    chk({tag, " sram_addr"}, 32'(sram_addr), 0);
    chk({tag, " sram_wdata"}, sram_wdata, 0);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " err_master"}, 32'(err_master), 0);
  endtask

  task automatic run(input int i, input vec_t t);
    string s = $sformatf("vec%0d", i);
    @(negedge clk);
    if (t.m) begin
      m1_valid = 1; m1_addr = t.addr; m1_wdata = t.wdata; m1_wstrb = t.wstrb;
    end else begin
      m0_valid = 1; m0_addr = t.addr; m0_wdata = t.wdata; m0_wstrb = t.wstrb;
    end
    @(negedge clk);
    chk({s, " sram_en"}, 32'(sram_en), 32'(t.en));
    chk({s, " sram_we"}, 32'(sram_we), 32'(t.we));
    if (t.en) chk({s, " sram_addr"}, 32'(sram_addr), 32'(t.saddr));
    if (t.en && t.wstrb != 0) chk({s, " sram_wdata"}, sram_wdata, t.wdata);
    chk({s, " early ready"}, 32'({m0_ready, m1_ready}), 0);
    @(negedge clk);
    chk({s, " m0_ready"}, 32'(m0_ready), 32'(!t.m));
    chk({s, " m1_ready"}, 32'(m1_ready), 32'(t.m));
    chk({s, " rdata"}, t.m ? m1_rdata : m0_rdata, t.rdata);
    chk({s, " other rdata"}, t.m ? m0_rdata : m1_rdata, 0);
    chk({s, " err"}, 32'(err), 32'(t.err));
    if (t.err) chk({s, " err_master"}, 32'(err_master), 32'(t.m));
    m0_valid = 0; m1_valid = 0;
  endtask

  initial begin
    logic [31:0] ba [4];
    logic [31:0] bd [4];
    v[0] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 4'h0, 10'd4, 32'hDEADBEEF, 1'b0};
    v[1] = '{1'b1, 32'h0000_0008, 32'h11223344, 4'b0010, 1'b1, 4'b0010, 10'd2, 32'h0, 1'b0};
    v[2] = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 1'b1, 4'h0, 10'd2, 32'hAABB33DD, 1'b0};
    v[3] = '{1'b1, 32'h0000_1000, 32'h0, 4'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1};
    v[4] = '{1'b0, 32'h0000_1000, 32'hFFFFFFFF, 4'hF, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1};
    v[5] = '{1'b1, 32'h0000_0FFF, 32'h0, 4'h0, 1'b1, 4'h0, 10'd1023, 32'hCAFEF00D, 1'b0};
    v[6] = '{1'b0, 32'h4000_0010, 32'h0, 4'h0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1};
    v[7] = '{1'b0, 32'h0000_000C, 32'h12345678, 4'hF, 1'b1, 4'hF, 10'd3, 32'h0, 1'b0};
    v[8] = '{1'b1, 32'h0000_000C, 32'h0, 4'h0, 1'b1, 4'h0, 10'd3, 32'h12345678, 1'b0};
    ba = '{32'h10, 32'h8, 32'hC, 32'hFFC};
    bd = '{32'hDEADBEEF, 32'hAABB33DD, 32'h12345678, 32'hCAFEF00D};

    // both masters requesting straight out of reset
    m0_valid = 1; m0_addr = 32'h10; m1_valid = 1; m1_addr = 32'hFFC;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 0;
    load = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("contend c%0d m0_ready", c), 32'(m0_ready), 32'(c % 3 == 2 && (c / 3) % 2 == 0));
      chk($sformatf("contend c%0d m1_ready", c), 32'(m1_ready), 32'(c % 3 == 2 && (c / 3) % 2 == 1));
      if (m0_ready) chk("contend m0_rdata", m0_rdata, 32'hDEADBEEF);
      if (m1_ready) chk("contend m1_rdata", m1_rdata, 32'hCAFEF00D);
    end
    m0_valid = 0; m1_valid = 0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run(i, v[i]);

    // reset during ACCESS of an m0 read
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 0;
    @(negedge clk);
    chk("midrst access en", 32'(sram_en), 1);
    rst = 1; m0_valid = 0;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst no ready", 32'({m0_ready, m1_ready, err}), 0);
    end
    run(9, v[0]);

    // back-to-back reads from m0 alone
    @(negedge clk);
    m0_valid = 1; m0_addr = ba[0]; m0_wstrb = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("b2b c%0d m0_ready", c), 32'(m0_ready), 32'(c % 3 == 2));
      chk($sformatf("b2b c%0d m1_ready", c), 32'(m1_ready), 0);
      if (c % 3 == 2) begin
        chk($sformatf("b2b c%0d rdata", c), m0_rdata, bd[c / 3]);
        if (c / 3 < 3) m0_addr = ba[c / 3 + 1];
        else m0_valid = 0;
      end
    end
    @(negedge clk);
    chk("b2b idle", 32'({m0_ready, sram_en}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
